// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: FIR MAC control FSM (buffer clear, sample write, MAC beats, pipeline drain, result handshake)
module fir_mac_sequencer #(
  parameter int FIR_DEPTH   = 256,
  parameter int PIPELINES   = 8,
  parameter int MAC_LATENCY = 4,
  parameter int ADDR_WIDTH  = $clog2(FIR_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_sample_valid,
  output logic                  o_sample_ready,
  output logic                  o_wr_en,
  output logic                  o_wr_zero,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_mac_en,
  output logic                  o_acc_clr,
  output logic                  o_acc_last,
  output logic [ADDR_WIDTH-1:0] o_tap_idx,
  output logic [ADDR_WIDTH-1:0] o_smp_addr,
  output logic                  o_result_valid,
  input  logic                  i_result_ready,
  output logic                  o_busy
);
  localparam int BEATS = FIR_DEPTH / PIPELINES;
  localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int DW    = $clog2(MAC_LATENCY + 1);
  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, COMPUTE, DRAIN, OUTPUT} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d, clr_q, clr_d, tap;
  logic [BW-1:0]         beat_q, beat_d;
  logic [DW-1:0]         drain_q, drain_d;
  logic                  act, gate, last_beat;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= CLEAR;
      head_q  <= '0;
      clr_q   <= '0;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      clr_q   <= clr_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    clr_d   = clr_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    if (i_en) begin
      case (state_q)
        CLEAR: begin
          clr_d   = clr_q + 1'b1;
          state_d = clr_q == ADDR_WIDTH'(FIR_DEPTH - 1) ? IDLE : CLEAR;
        end
        IDLE:  state_d = i_sample_valid ? WRITE : IDLE;
        WRITE: begin
          beat_d  = '0;
          state_d = COMPUTE;
        end
        COMPUTE: begin
          beat_d  = beat_q + 1'b1;
          head_d  = last_beat ? head_q + 1'b1 : head_q;
          drain_d = '0;
          state_d = last_beat ? DRAIN : COMPUTE;
        end
        DRAIN: begin
          drain_d = drain_q + 1'b1;
          state_d = drain_q == DW'(MAC_LATENCY - 1) ? OUTPUT : DRAIN;
        end
        OUTPUT:  state_d = i_result_ready ? IDLE : OUTPUT;
        default: state_d = CLEAR;
      endcase
    end
  end
  assign act       = !i_rst;
  assign gate      = act && i_en;
  assign last_beat = beat_q == BW'(BEATS - 1);
  assign tap       = ADDR_WIDTH'(beat_q) << $clog2(PIPELINES);
  always_comb begin
    o_sample_ready = gate && state_q == IDLE;
    o_wr_en        = gate && (state_q == CLEAR || state_q == WRITE);
    o_wr_zero      = act && state_q == CLEAR;
    o_wr_addr      = !act ? '0 : state_q == CLEAR ? clr_q : state_q == WRITE ? head_q : '0;
    o_mac_en       = gate && state_q == COMPUTE;
    o_acc_clr      = o_mac_en && beat_q == '0;
    o_acc_last     = o_mac_en && last_beat;
    o_tap_idx      = act && state_q == COMPUTE ? tap : '0;
    o_smp_addr     = act && state_q == COMPUTE ? head_q - tap : '0;
    o_result_valid = act && state_q == OUTPUT;
    o_busy         = act && state_q != IDLE;
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed vector table, corner sequences and random run against a transaction-level model
module tb_fir_mac_sequencer;
  localparam int DEPTH = 256, P = 8, LAT = 4, BEATS = DEPTH / P;
  logic i_clk = 0, i_rst = 1, i_en = 0, i_sample_valid = 0, i_result_ready = 0;
  logic o_sample_ready, o_wr_en, o_wr_zero, o_mac_en, o_acc_clr, o_acc_last, o_result_valid, o_busy;
  logic [7:0] o_wr_addr, o_tap_idx, o_smp_addr;
  logic [31:0] dut_vec;
  int checks = 0, failures = 0;
  int mode = 0, c = 0, t = 0, n = 0;
  always #5 i_clk = ~i_clk;
  fir_mac_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_sample_valid(i_sample_valid),
    .o_sample_ready(o_sample_ready), .o_wr_en(o_wr_en), .o_wr_zero(o_wr_zero),
    .o_wr_addr(o_wr_addr), .o_mac_en(o_mac_en), .o_acc_clr(o_acc_clr),
    .o_acc_last(o_acc_last), .o_tap_idx(o_tap_idx), .o_smp_addr(o_smp_addr),
    .o_result_valid(o_result_valid), .i_result_ready(i_result_ready), .o_busy(o_busy)
  );
  assign dut_vec = {o_sample_ready, o_wr_en, o_wr_zero, o_wr_addr, o_mac_en, o_acc_clr,
                    o_acc_last, o_tap_idx, o_smp_addr, o_result_valid, o_busy};
  function automatic logic [31:0] pk(logic sr, logic we, logic wz, logic [7:0] wa, logic me,
                                     logic ac, logic al, logic [7:0] tp, logic [7:0] sa,
                                     logic rv, logic bz);
    return {sr, we, wz, wa, me, ac, al, tp, sa, rv, bz};
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  // mode 0: clearing (c = entries zeroed), 1: idle, 2: sample in flight (t = enabled cycles since accept)
  function automatic logic [31:0] model_out(logic r, logic e);
    int b;
    if (r) return '0;
    if (mode == 0) return pk(0, e, 1, 8'(c), 0, 0, 0, 0, 0, 0, 1);
    if (mode == 1) return pk(e, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (t == 0) return pk(0, e, 0, 8'(n), 0, 0, 0, 0, 0, 0, 1);
    if (t <= BEATS) begin
      b = t - 1;
      return pk(0, 0, 0, 0, e, e && b == 0, e && b == BEATS - 1, 8'(b * P), 8'(n - b * P), 0, 1);
    end
    return pk(0, 0, 0, 0, 0, 0, 0, 0, 0, t > BEATS + LAT, 1);
  endfunction
  task automatic step(input logic r, input logic e, input logic v, input logic rd, input string name);
    i_rst = r; i_en = e; i_sample_valid = v; i_result_ready = rd;
    #1;
    chk(name, dut_vec, model_out(r, e));
    @(posedge i_clk);
    if (r) begin
      mode = 0; c = 0; t = 0; n = 0;
    end else if (e) begin
      if (mode == 0) begin
        c++;
        if (c == DEPTH) mode = 1;
      end else if (mode == 1) begin
        if (v) begin mode = 2; t = 0; end
      end else if (t == BEATS + LAT + 1) begin
        if (rd) begin mode = 1; n++; end
      end else t++;
    end
    @(negedge i_clk);
  endtask
  typedef struct {int cyc; logic r, e, v, rd; logic [31:0] exp;} vec_t;
  vec_t tbl[19];
  int lat;
  initial begin
    tbl[0]  = '{2,   1, 1, 0, 0, pk(0, 0, 0, 0,   0, 0, 0, 0,   0,   0, 0)};
    tbl[1]  = '{1,   0, 1, 0, 0, pk(0, 1, 1, 1,   0, 0, 0, 0,   0,   0, 1)};
    tbl[2]  = '{3,   0, 0, 0, 0, pk(0, 0, 1, 1,   0, 0, 0, 0,   0,   0, 1)};
    tbl[3]  = '{254, 0, 1, 0, 0, pk(0, 1, 1, 255, 0, 0, 0, 0,   0,   0, 1)};
    tbl[4]  = '{1,   0, 1, 0, 0, pk(1, 0, 0, 0,   0, 0, 0, 0,   0,   0, 0)};
    tbl[5]  = '{1,   0, 1, 1, 0, pk(0, 1, 0, 0,   0, 0, 0, 0,   0,   0, 1)};
    tbl[6]  = '{1,   0, 1, 0, 0, pk(0, 0, 0, 0,   1, 1, 0, 0,   0,   0, 1)};
    tbl[7]  = '{1,   0, 1, 0, 0, pk(0, 0, 0, 0,   1, 0, 0, 8,   248, 0, 1)};
    tbl[8]  = '{30,  0, 1, 0, 0, pk(0, 0, 0, 0,   1, 0, 1, 248, 8,   0, 1)};
    tbl[9]  = '{1,   0, 1, 0, 0, pk(0, 0, 0, 0,   0, 0, 0, 0,   0,   0, 1)};
    tbl[10] = '{3,   0, 1, 0, 0, pk(0, 0, 0, 0,   0, 0, 0, 0,   0,   0, 1)};
    tbl[11] = '{1,   0, 1, 0, 0, pk(0, 0, 0, 0,   0, 0, 0, 0,   0,   1, 1)};
    tbl[12] = '{5,   0, 1, 1, 0, pk(0, 0, 0, 0,   0, 0, 0, 0,   0,   1, 1)};
    tbl[13] = '{3,   0, 0, 0, 1, pk(0, 0, 0, 0,   0, 0, 0, 0,   0,   1, 1)};
    tbl[14] = '{1,   0, 1, 0, 1, pk(1, 0, 0, 0,   0, 0, 0, 0,   0,   0, 0)};
    tbl[15] = '{1,   0, 1, 1, 0, pk(0, 1, 0, 1,   0, 0, 0, 0,   0,   0, 1)};
    tbl[16] = '{13,  0, 1, 0, 0, pk(0, 0, 0, 0,   1, 0, 0, 96,  161, 0, 1)};
    tbl[17] = '{1,   1, 1, 0, 0, pk(0, 0, 0, 0,   0, 0, 0, 0,   0,   0, 0)};
    tbl[18] = '{1,   0, 1, 0, 0, pk(0, 1, 1, 1,   0, 0, 0, 0,   0,   0, 1)};
    for (int i = 0; i < 19; i++) begin
      i_rst = tbl[i].r; i_en = tbl[i].e; i_sample_valid = tbl[i].v; i_result_ready = tbl[i].rd;
      repeat (tbl[i].cyc) @(posedge i_clk);
      #1;
      chk($sformatf("vec%0d", i), dut_vec, tbl[i].exp);
    end
    @(negedge i_clk);
    repeat (2) step(1, 1, 0, 0, "reset");
    repeat (DEPTH) step(0, 1, 0, 0, "clear");
    step(0, 1, 1, 0, "accept_drop");
    lat = 0;
    while (!o_result_valid && lat < 200) begin
      step(0, !(lat >= 6 && lat < 16), 0, 0, "en_drop");
      lat++;
    end
    checks++;
    if (lat != BEATS + LAT + 1 + 10) begin
      failures++;
      $display("FAIL latency_en_drop got=%0d exp=%0d", lat, BEATS + LAT + 1 + 10);
    end
    step(0, 1, 0, 1, "consume");
    step(0, 1, 1, 0, "accept_bp");
    repeat (BEATS + LAT + 1) step(0, 1, 0, 0, "to_output");
    repeat (100) step(0, 1, 1, 0, "backpressure");
    step(0, 1, 1, 1, "bp_release");
    step(0, 1, 0, 0, "idle_after_bp");
    step(0, 1, 1, 0, "accept_rst");
    repeat (13) step(0, 1, 0, 0, "to_beat12");
    step(1, 1, 0, 0, "rst_mid");
    repeat (DEPTH) step(0, 1, 0, 0, "reclear");
    step(0, 1, 0, 0, "idle_after_reclear");
    repeat (257 * (BEATS + LAT + 3)) step(0, 1, 1, 1, "back_to_back");
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), "random");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
